// File: rtl/barrier_ctrl.sv
// Gate control FSM: synchronises the sensors, sequences the speed-measurement datapath
// and decides whether to admit, reject or flag each vehicle.
module barrier_ctrl #(
  parameter int unsigned WIDTH_SPEED    = 14,
  parameter int unsigned SPEED_LIMIT    = 60,
  parameter int unsigned MAX_VEH        = 3,
  parameter int unsigned MIN_CYCLES     = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter int unsigned CALC_LIMIT     = 64,
  parameter int unsigned HOLD_CYCLES    = 100000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sen_a,
  input  logic                   sen_b,
  input  logic                   sen_exit,
  input  logic                   man_open,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   done,
  input  logic [1:0]             num_veh,
  output logic                   init,
  output logic                   count,
  output logic                   cal,
  output logic                   up,
  output logic                   down,
  output logic                   en,
  output logic                   dis,
  output logic                   viol,
  output logic                   full_rej,
  output logic                   abort,
  output logic [WIDTH_SPEED-1:0] speed_q,
  output logic [2:0]             state
);

  localparam int unsigned CycMax0 = (TIMEOUT_CYCLES > CALC_LIMIT) ? TIMEOUT_CYCLES : CALC_LIMIT;
  localparam int unsigned CycMax  = (CycMax0 > MIN_CYCLES) ? CycMax0 : MIN_CYCLES;
  localparam int unsigned CycW    = $clog2(CycMax + 1);
  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);

  localparam logic [CycW-1:0]        TimeoutLast = CycW'(TIMEOUT_CYCLES - 1);
  localparam logic [CycW-1:0]        CalcLast    = CycW'(CALC_LIMIT - 1);
  localparam logic [CycW-1:0]        MinCyc      = CycW'(MIN_CYCLES);
  localparam logic [HoldW-1:0]       HoldLast    = HoldW'(HOLD_CYCLES - 1);
  localparam logic [1:0]             MaxVeh      = 2'(MAX_VEH);
  localparam logic [WIDTH_SPEED-1:0] SpeedLimit  = WIDTH_SPEED'(SPEED_LIMIT);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StTiming = 3'd1,
    StCalc   = 3'd2,
    StDecide = 3'd3,
    StAdmit  = 3'd4,
    StHold   = 3'd5,
    StViol   = 3'd6
  } state_e;

  // Bit order: 0 = sen_a, 1 = sen_b, 2 = sen_exit, 3 = man_open.
  logic [3:0] async_in, meta_q, sync_q, prev_q, rise;
  logic       a_rise, b_rise, exit_rise, man_rise, b_level;

  state_e                 state_q, state_d;
  logic [CycW-1:0]        cyc_q, cyc_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [WIDTH_SPEED-1:0] speed_d;
  logic init_d, cal_d, up_d, down_d, en_d, dis_d, viol_d, full_d, abort_d;

  assign async_in  = {man_open, sen_exit, sen_b, sen_a};
  assign rise      = sync_q & ~prev_q;
  assign a_rise    = rise[0];
  assign b_rise    = rise[1];
  assign exit_rise = rise[2];
  assign man_rise  = rise[3];
  assign b_level   = sync_q[1];

  assign count = (state_q == StTiming);
  assign state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      state_q  <= StIdle;
      cyc_q    <= '0;
      hold_q   <= '0;
      speed_q  <= '0;
      init     <= 1'b0;
      cal      <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      en       <= 1'b0;
      dis      <= 1'b0;
      viol     <= 1'b0;
      full_rej <= 1'b0;
      abort    <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      hold_q   <= hold_d;
      speed_q  <= speed_d;
      init     <= init_d;
      cal      <= cal_d;
      up       <= up_d;
      down     <= down_d;
      en       <= en_d;
      dis      <= dis_d;
      viol     <= viol_d;
      full_rej <= full_d;
      abort    <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    hold_d  = hold_q;
    speed_d = speed_q;
    init_d  = 1'b0;
    cal_d   = 1'b0;
    up_d    = 1'b0;
    en_d    = 1'b0;
    dis_d   = 1'b0;
    viol_d  = 1'b0;
    full_d  = 1'b0;
    abort_d = 1'b0;
    // Exit handling is independent of the FSM; an empty lot never decrements.
    down_d  = exit_rise && (num_veh != 2'd0);

    unique case (state_q)
      StIdle: begin
        if (a_rise) begin
          if (num_veh >= MaxVeh) begin
            full_d = 1'b1;
          end else begin
            init_d  = 1'b1;
            cyc_d   = '0;
            state_d = StTiming;
          end
        end else if (man_rise) begin
          en_d    = 1'b1;
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StTiming: begin
        cyc_d = cyc_q + 1'b1;
        if (b_rise) begin
          if (cyc_q < MinCyc) begin
            speed_d = '1;
            state_d = StViol;
          end else begin
            cal_d   = 1'b1;
            cyc_d   = '0;
            state_d = StCalc;
          end
        end else if (cyc_q == TimeoutLast) begin
          abort_d = 1'b1;
          init_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StCalc: begin
        cyc_d = cyc_q + 1'b1;
        // done may still be stale during the cycle cal is out; ignore it there.
        if (done && !cal) begin
          speed_d = speed;
          state_d = StDecide;
        end else if (cyc_q == CalcLast) begin
          abort_d = 1'b1;
          init_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StDecide: begin
        state_d = (speed_q <= SpeedLimit) ? StAdmit : StViol;
      end
      StAdmit: begin
        if (num_veh >= MaxVeh) begin
          full_d  = 1'b1;
          state_d = StIdle;
        end else begin
          up_d    = 1'b1;
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (b_level) begin
          hold_d = '0;
        end else if (hold_q == HoldLast) begin
          dis_d   = 1'b1;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StViol: begin
        viol_d  = 1'b1;
        init_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_barrier_ctrl.sv
// Bench for barrier_ctrl: directed scenarios, then random vehicles checked against
// an outcome-level model of one gate transaction.
module tb_barrier_ctrl;

  localparam int unsigned WS   = 14;
  localparam int unsigned LIM  = 60;
  localparam int unsigned MAXV = 3;
  localparam int unsigned MINC = 20;
  localparam int unsigned TOUT = 400;
  localparam int unsigned CLIM = 64;
  localparam int unsigned HOLD = 300;
  localparam int          LAT  = 3;  // input rise to visible strobe

  localparam int IInit = 0, ICal = 1, IUp = 2, IDown = 3, IEn = 4;
  localparam int IDis = 5, IViol = 6, IFull = 7, IAbort = 8, NEv = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sen_a = 1'b0, sen_b = 1'b0, sen_exit = 1'b0, man_open = 1'b0;
  logic [WS-1:0] speed = '0;
  logic          done = 1'b0;
  logic [1:0]    num_veh = 2'd0;
  logic          init, count, cal, up, down, en, dis, viol, full_rej, abort;
  logic [WS-1:0] speed_q;
  logic [2:0]    state;

  int n[NEv], t[NEv], base[NEv], e[NEv];
  int cyc, total, bad, dcnt, div_lat;
  int ta, tb_t, t0;
  logic [WS-1:0] sq_exp;

  always #5 clk = ~clk;

  barrier_ctrl #(
    .WIDTH_SPEED(WS), .SPEED_LIMIT(LIM), .MAX_VEH(MAXV), .MIN_CYCLES(MINC),
    .TIMEOUT_CYCLES(TOUT), .CALC_LIMIT(CLIM), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sen_a(sen_a), .sen_b(sen_b), .sen_exit(sen_exit),
    .man_open(man_open), .speed(speed), .done(done), .num_veh(num_veh), .init(init),
    .count(count), .cal(cal), .up(up), .down(down), .en(en), .dis(dis), .viol(viol),
    .full_rej(full_rej), .abort(abort), .speed_q(speed_q), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample away from the edge, tally strobes and run the divider model.
  task automatic tick();
    logic [NEv-1:0] p;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    p = {abort, full_rej, viol, dis, en, down, up, cal, init};
    for (int i = 0; i < NEv; i++) if (p[i]) begin n[i]++; t[i] = cyc; end
    if (init) begin done = 1'b0; dcnt = -1; end
    else if (cal) dcnt = div_lat;
    else if (dcnt > 0) dcnt--;
    if (dcnt == 0) done = 1'b1;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < NEv; i++) base[i] = n[i];
  endtask

  function automatic int dn(input int i);
    return n[i] - base[i];
  endfunction

  // A pulses at k=0, B (if d >= 0) at k=d for bw cycles; optional occupancy change after B.
  task automatic vehicle(input int d, input int bw, input int nv_late, input int win,
                         output int ta_o, output int tb_o);
    ta_o = cyc;
    tb_o = -1;
    for (int k = 0; k < win; k++) begin
      sen_a = (k < 2);
      sen_b = (d >= 0) && (k >= d) && (k < d + bw);
      if (d >= 0 && k == d) tb_o = cyc;
      if (d >= 0 && nv_late >= 0 && k == d + 1) num_veh = 2'(nv_late);
      tick();
    end
    sen_a = 1'b0;
    sen_b = 1'b0;
  endtask

  // Outcome of one transaction from the gate rules, in strobe counts and final speed_q.
  task automatic model(input int nv, input int d, input int l, input int spd);
    for (int i = 0; i < NEv; i++) e[i] = 0;
    if (nv >= int'(MAXV)) begin
      e[IFull] = 1;
    end else if (d < 0) begin
      e[IInit] = 2; e[IAbort] = 1;
    end else if (d < int'(MINC)) begin
      e[IInit] = 2; e[IViol] = 1; sq_exp = '1;
    end else begin
      e[ICal] = 1;
      if (l < 0) begin
        e[IInit] = 2; e[IAbort] = 1;
      end else if (spd <= int'(LIM)) begin
        e[IInit] = 1; e[IUp] = 1; e[IDis] = 1; sq_exp = WS'(spd);
      end else begin
        e[IInit] = 2; e[IViol] = 1; sq_exp = WS'(spd);
      end
    end
  endtask

  initial begin
    int nv, d, l, spd;
    total = 0; bad = 0; cyc = 0; dcnt = -1; div_lat = 0;

    // Reset
    run(3);
    chk("reset_outs", {init, count, cal, up, down, en, dis, viol, full_rej, abort}, 0);
    chk("reset_state", state, 0);
    chk("reset_speed_q", speed_q, 0);
    reset_n = 1'b1;
    run(3);

    // Admit at legal speed
    num_veh = 2'd0; speed = 14'd48; div_lat = 2; snap();
    vehicle(MINC + 30, 2, -1, MINC + 30 + HOLD + 40, ta, tb_t);
    chk("adm_init_t", t[IInit], ta + LAT);
    chk("adm_cal_t", t[ICal], tb_t + LAT);
    chk("adm_up_n", dn(IUp), 1);
    chk("adm_up_t", t[IUp], tb_t + LAT + 2 + 3);
    chk("adm_speed_q", speed_q, 48);
    chk("adm_dis_n", dn(IDis), 1);
    chk("adm_dis_gap", t[IDis] - t[IUp], HOLD);
    chk("adm_no_viol", dn(IViol) + dn(IEn) + dn(IAbort), 0);

    // Overspeed from the divider
    speed = 14'd72; div_lat = 3; snap();
    vehicle(MINC + 10, 2, -1, MINC + 60, ta, tb_t);
    chk("ovs_viol_n", dn(IViol), 1);
    chk("ovs_speed_q", speed_q, 72);
    chk("ovs_no_open", dn(IUp) + dn(IEn) + dn(IDis), 0);
    chk("ovs_init_n", dn(IInit), 2);

    // Window too short to divide
    speed = 14'd5; snap();
    vehicle(5, 2, -1, 40, ta, tb_t);
    chk("short_viol_n", dn(IViol), 1);
    chk("short_speed_q", speed_q, 14'h3FFF);
    chk("short_no_cal", dn(ICal), 0);

    // Full lot, then an exit
    num_veh = 2'd3; snap();
    vehicle(-1, 0, -1, 20, ta, tb_t);
    chk("full_rej_n", dn(IFull), 1);
    chk("full_rej_t", t[IFull], ta + LAT);
    chk("full_no_init", dn(IInit), 0);
    chk("full_state", state, 0);
    t0 = cyc; sen_exit = 1'b1; run(2); sen_exit = 1'b0; run(10);
    chk("exit_down_n", dn(IDown), 1);
    chk("exit_down_t", t[IDown], t0 + LAT);

    // Exit with empty lot
    num_veh = 2'd0; snap();
    sen_exit = 1'b1; run(2); sen_exit = 1'b0; run(10);
    chk("exit_empty_down", dn(IDown), 0);

    // Timeout waiting for B
    num_veh = 2'd1; snap(); ta = cyc;
    sen_a = 1'b1; run(2); sen_a = 1'b0; run(5);
    chk("tmo_count_hi", count, 1);
    run(TOUT + 10);
    chk("tmo_abort_n", dn(IAbort), 1);
    chk("tmo_abort_t", t[IAbort], ta + LAT + TOUT);
    chk("tmo_init_n", dn(IInit), 2);
    chk("tmo_count_lo", count, 0);

    // Divider never answers
    div_lat = -1; snap();
    vehicle(MINC + 30, 2, -1, MINC + 30 + CLIM + 20, ta, tb_t);
    chk("calc_abort_n", dn(IAbort), 1);
    chk("calc_abort_gap", t[IAbort] - t[ICal], CLIM);
    chk("calc_no_up", dn(IUp), 0);

    // Vehicle lingers under the barrier
    num_veh = 2'd0; speed = 14'd30; div_lat = 2; snap();
    vehicle(MINC + 30, 150, -1, MINC + 30 + 150 + HOLD + 20, ta, tb_t);
    chk("hext_up_n", dn(IUp), 1);
    chk("hext_dis_t", t[IDis], tb_t + 150 + 2 + HOLD);

    // Manual open
    snap(); t0 = cyc;
    man_open = 1'b1; run(2); man_open = 1'b0; run(HOLD + 20);
    chk("man_en_t", t[IEn], t0 + LAT);
    chk("man_dis_gap", t[IDis] - t[IEn], HOLD);
    chk("man_no_up", dn(IUp) + dn(IInit), 0);

    // Lot fills while the speed is computed
    num_veh = 2'd2; speed = 14'd30; div_lat = 5; snap();
    vehicle(MINC + 30, 2, 3, MINC + 30 + 40, ta, tb_t);
    chk("grd_full_n", dn(IFull), 1);
    chk("grd_no_up", dn(IUp) + dn(IDis), 0);
    chk("grd_speed_q", speed_q, 30);
    chk("grd_state", state, 0);

    // Reset in the middle of TIMING
    num_veh = 2'd0; snap();
    sen_a = 1'b1; run(2); sen_a = 1'b0; run(10);
    chk("rst_mid_count", count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {init, count, cal, up, down, en, dis, viol, full_rej, abort}, 0);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_speed_q", speed_q, 0);
    run(3);
    reset_n = 1'b1;
    run(2);
    chk("rst_no_dis", dn(IDis), 0);
    snap(); ta = cyc;
    sen_a = 1'b1; run(2); sen_a = 1'b0; run(3);
    chk("rst_init_n", dn(IInit), 1);
    chk("rst_init_t", t[IInit], ta + LAT);
    run(TOUT + 10);
    sq_exp = '0;

    // Random vehicles
    for (int r = 0; r < 14; r++) begin
      nv  = $urandom_range(0, 3);
      spd = ($urandom_range(0, 7) == 0) ? 16000 : $urandom_range(0, 130);
      l   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0:       d = -1;
        1, 2:    d = $urandom_range(3, MINC - 5);
        default: d = $urandom_range(MINC + 5, TOUT - 50);
      endcase
      num_veh = 2'(nv); speed = WS'(spd); div_lat = l;
      model(nv, d, l, spd);
      snap();
      vehicle(d, 2, -1, TOUT + HOLD + 50, ta, tb_t);
      for (int i = 0; i < NEv; i++) chk($sformatf("rnd%0d_ev%0d", r, i), dn(i), e[i]);
      chk($sformatf("rnd%0d_speed_q", r), speed_q, sq_exp);
      chk($sformatf("rnd%0d_state", r), state, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrier_ctrl.md
Name: barrier_ctrl

Overview:
- Control FSM that sequences the speed-measurement and barrier datapath for the gate.
- Watches the entry sensors A and B, the exit sensor and a manual-open request.
- Drives the datapath strobes: init, count, cal, up, down, en, dis.
- Reads the datapath results (speed, done, num_veh) to admit a vehicle, reject it as full, or flag it as overspeed.

Parameters:
- WIDTH_SPEED, 14, width of the speed input and of speed_q.
- SPEED_LIMIT, 60, admit if speed <= this value; 14400/60 = 240 ms between sensors.
- MAX_VEH, 3, occupancy at which entry is rejected (num_veh width is 2).
- MIN_CYCLES, 50000, a timing window shorter than this (1 ms at 50 MHz) is an overspeed without division.
- TIMEOUT_CYCLES, 25000000, abort limit for the TIMING state (500 ms, below the 9-bit ms wrap).
- CALC_LIMIT, 64, cycles to wait for done before aborting.
- HOLD_CYCLES, 100000000, barrier open time (2 s).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- sen_a  in  1  entry sensor A, async level, active high
- sen_b  in  1  entry sensor B, async level, active high
- sen_exit  in  1  exit sensor, async level, active high
- man_open  in  1  manual open request, async level, active high
- speed  in  WIDTH_SPEED  quotient from the datapath
- done  in  1  divider done (level; only its first high cycle in CALC is used)
- num_veh  in  2  current occupancy
- init  out  1  clears the timers and the divider
- count  out  1  ms timer enable
- cal  out  1  starts the division
- up  out  1  occupancy +1 and open barrier
- down  out  1  occupancy -1
- en  out  1  open barrier without counting
- dis  out  1  close barrier
- viol  out  1  overspeed event, 1-cycle pulse
- full_rej  out  1  entry rejected because full, 1-cycle pulse
- abort  out  1  timeout or error, 1-cycle pulse
- speed_q  out  WIDTH_SPEED  last classified speed; 0x3FFF marks a sub-MIN_CYCLES window
- state  out  3  current FSM state encoding

Behaviour:
- Reset: every output is 0, speed_q is 0, state is IDLE, all counters are 0. Reset mid-operation returns to IDLE immediately and issues no dis; the datapath reset closes the barrier.
- Inputs: every async input passes a 2-flop synchroniser, then a rising-edge detector. Fixed latency from input rise to the event cycle is 3 clocks.
- Except count, every strobe is a registered 1-cycle pulse.
- States: IDLE=0, TIMING=1, CALC=2, DECIDE=3, ADMIT=4, HOLD=5, VIOL=6.
- IDLE:
  - A_rise with num_veh >= MAX_VEH: pulse full_rej, stay in IDLE.
  - A_rise otherwise: pulse init, clear the cycle counter cyc, go to TIMING.
  - man_open rise (A_rise takes priority): pulse en, go to HOLD.
- TIMING:
  - count = 1 and cyc increments every cycle.
  - B_rise with cyc < MIN_CYCLES: speed_q = all-ones, go to VIOL.
  - B_rise otherwise: pulse cal, clear cyc, go to CALC.
  - cyc == TIMEOUT_CYCLES-1 with no B_rise: pulse abort and init, go to IDLE.
  - A_rise while in TIMING is ignored.
- CALC:
  - count = 0, cyc increments.
  - done high and it is not the cal cycle: latch speed into speed_q, go to DECIDE.
  - cyc == CALC_LIMIT-1: pulse abort and init, go to IDLE.
- DECIDE: speed_q <= SPEED_LIMIT goes to ADMIT, otherwise VIOL. The comparison is unsigned.
- ADMIT: pulse up, clear the hold counter, go to HOLD.
- HOLD:
  - Hold counter increments every cycle.
  - Counter is cleared while synchronised sen_b is high (vehicle under the barrier).
  - At HOLD_CYCLES-1: pulse dis, go to IDLE.
- VIOL: pulse viol and init, go to IDLE. The barrier is not opened.
- Exit handling runs independently of the FSM:
  - exit_rise with num_veh != 0 pulses down; with num_veh == 0 it is ignored (no underflow).
  - If down coincides with up, both are still issued; the net change is 0 by datapath rule.
- Occupancy: up is never issued when num_veh == MAX_VEH (guarded in IDLE and again in ADMIT; an ADMIT with full occupancy pulses full_rej and goes to IDLE). The 2-bit wrap can never occur.
- The state output is registered and equals the current state.

Test Plan:
- Reset: reset_n low mid-TIMING -> all outputs 0, state = 0; after release, sen_a rises -> init appears 3 clocks later.
- Admit: sen_a rise, then sen_b rise 300 ms later, speed model returns 48 with done -> up pulse once, speed_q = 48; dis pulse HOLD_CYCLES after up, with sen_b low throughout.
- Overspeed: interval 200 ms, speed = 72 -> viol pulse, speed_q = 72, no up/en/dis; interval 0.5 ms -> viol, speed_q = 0x3FFF, cal never asserted.
- Full: num_veh = 3, sen_a rise -> full_rej pulse, no init, state stays 0; sen_exit rise -> exactly one down pulse.
- Timeouts: sen_a with no sen_b for 500 ms -> abort and init, count drops; cal issued with done never rising -> abort after 64 cycles.
- Hold extension and manual open: sen_b held high for 1 s in HOLD -> dis at 1 s + HOLD_CYCLES; man_open in IDLE -> en pulse then dis; exit with num_veh = 0 -> no down.
